// File: rtl/id_if.sv
// id_if: bundle between the ID stage and its neighbours (IF instruction
// stream and BR read port, EX/WB write-back and flag update, decoded
// operands to EX, branch feedback to IF).
interface id_if;
  logic [31:0] instr_in;
  logic [2:0]  br_addr;
  logic [31:0] br_value;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [31:0] wb_data;
  logic        write_enable;
  logic [2:0]  write_addr;
  logic [31:0] write_value;
  logic        flags_we;
  logic [3:0]  flags_in;
  logic        b_cond;
  logic [15:0] b_relAddr;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_rd;
  logic [31:0] ex_op_a;
  logic [31:0] ex_op_b;

  modport slave (
    input  instr_in, br_addr, wb_en, wb_addr, wb_data, flags_we, flags_in,
    output br_value, write_enable, write_addr, write_value,
           b_cond, b_relAddr, ex_valid, ex_opcode, ex_rd, ex_op_a, ex_op_b
  );

  modport master (
    output instr_in, br_addr, wb_en, wb_addr, wb_data, flags_we, flags_in,
    input  br_value, write_enable, write_addr, write_value,
           b_cond, b_relAddr, ex_valid, ex_opcode, ex_rd, ex_op_a, ex_op_b
  );
endinterface

// File: rtl/id_stage.sv
// id_stage: instruction decode with 8x32 register file, NZCV flags,
// conditional branch evaluation and wrong-path squash.
// Optional macro ID_FLAG_FWD_EN: conditional branches see flags_in in the
// same cycle as a flag update instead of the (one cycle stale) flags register.
//
// state     | meaning
// ST_RUN    | normal decode
// ST_SQUASH | discarding wrong-path instructions after a taken Bcond
module id_stage #(
  parameter int          SQUASH_SLOTS = 2,
  parameter logic [31:0] NOP_WORD     = 32'hC8000000
) (
  input logic clk,
  input logic rst_n,
  id_if.slave bus
);
  localparam logic [6:0] OP_B  = 7'b1100000;
  localparam logic [6:0] OP_BC = 7'b1100001;
  localparam logic [6:0] OP_BR = 7'b1100010;

  typedef enum logic {ST_RUN, ST_SQUASH} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_rf [8];
  logic [3:0]  r_flags;

  logic        r_b_cond;
  logic [15:0] r_b_rel;
  logic        r_ex_valid;
  logic [6:0]  r_ex_opcode;
  logic [2:0]  r_ex_rd;
  logic [31:0] r_ex_op_a, r_ex_op_b;

  logic [31:0] w_instr;
  logic [6:0]  w_opcode;
  logic [2:0]  w_rs1, w_rs2;
  logic [15:0] w_imm;
  logic [31:0] w_op_a, w_op_b;
  logic [3:0]  w_flags;
  logic        w_cond_true, w_taken, w_valid;

  // While squashing, the incoming word is replaced by a NOP so nothing downstream fires.
  assign w_instr  = (r_state == ST_SQUASH) ? NOP_WORD : bus.instr_in;
  assign w_opcode = w_instr[31:25];
  assign w_rs1    = w_instr[21:19];
  assign w_rs2    = w_instr[18:16];
  assign w_imm    = w_instr[15:0];

  assign w_op_a = (bus.wb_en && bus.wb_addr == w_rs1) ? bus.wb_data : r_rf[w_rs1];
  assign w_op_b = w_opcode[0] ? {{16{w_imm[15]}}, w_imm}
                : (bus.wb_en && bus.wb_addr == w_rs2) ? bus.wb_data : r_rf[w_rs2];

`ifdef ID_FLAG_FWD_EN
  assign w_flags = bus.flags_we ? bus.flags_in : r_flags;
`else
  assign w_flags = r_flags;
`endif

  // Condition code evaluation on {N,Z,C,V}.
  always_comb begin
    w_cond_true = 1'b0;
    case (w_instr[24:21])
      4'd0: w_cond_true =  w_flags[2];
      4'd1: w_cond_true = !w_flags[2];
      4'd2: w_cond_true =  w_flags[1];
      4'd3: w_cond_true = !w_flags[1];
      4'd4: w_cond_true =  w_flags[3];
      4'd5: w_cond_true = !w_flags[3];
      4'd6: w_cond_true =  w_flags[0];
      4'd7: w_cond_true = !w_flags[0];
      4'd8: w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  assign w_taken = (w_opcode == OP_BC) && w_cond_true;
  assign w_valid = (w_instr != NOP_WORD) && (w_opcode != OP_B) &&
                   (w_opcode != OP_BR) && (w_opcode != OP_BC);

  // Next-state and squash counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_taken) begin
          w_state_nxt = ST_SQUASH;
          w_cnt_nxt   = 2'(SQUASH_SLOTS);
        end
      end
      ST_SQUASH: begin
        w_cnt_nxt = r_cnt - 2'd1;
        if (r_cnt == 2'd1) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Register file and flags; writes continue regardless of squash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_rf[i] <= 32'd0;
      r_flags <= 4'd0;
    end else begin
      if (bus.wb_en)    r_rf[bus.wb_addr] <= bus.wb_data;
      if (bus.flags_we) r_flags <= bus.flags_in;
    end
  end

  // Decode outputs to EX and branch pulse to IF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_cond    <= 1'b0;
      r_b_rel     <= 16'd0;
      r_ex_valid  <= 1'b0;
      r_ex_opcode <= NOP_WORD[31:25];
      r_ex_rd     <= 3'd0;
      r_ex_op_a   <= 32'd0;
      r_ex_op_b   <= 32'd0;
    end else begin
      r_b_cond    <= w_taken;
      r_b_rel     <= w_taken ? w_imm : 16'd0;
      r_ex_valid  <= w_valid;
      r_ex_opcode <= w_opcode;
      r_ex_rd     <= w_instr[24:22];
      r_ex_op_a   <= w_op_a;
      r_ex_op_b   <= w_op_b;
    end
  end

  assign bus.br_value     = r_rf[bus.br_addr];
  assign bus.write_enable = bus.wb_en;
  assign bus.write_addr   = bus.wb_addr;
  assign bus.write_value  = bus.wb_data;
  assign bus.b_cond       = r_b_cond;
  assign bus.b_relAddr    = r_b_rel;
  assign bus.ex_valid     = r_ex_valid;
  assign bus.ex_opcode    = r_ex_opcode;
  assign bus.ex_rd        = r_ex_rd;
  assign bus.ex_op_a      = r_ex_op_a;
  assign bus.ex_op_b      = r_ex_op_b;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and randomized checks of id_stage against a
// behavioural model of the register file, flags and squash window.
module tb_id_stage;
  localparam int          SLOTS = 2;
  localparam logic [31:0] NOP   = 32'hC8000000;
  localparam logic [6:0]  ADD   = 7'b0000010;
  localparam logic [6:0]  ADDI  = 7'b0000011;
`ifdef ID_FLAG_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_if bus ();
  id_stage #(.SQUASH_SLOTS(SLOTS), .NOP_WORD(NOP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] m_rf [8];
  logic [3:0]  m_flags;
  int          m_squash;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  function automatic logic [31:0] mkbc(input logic [3:0] c, input logic [15:0] imm);
    return {7'b1100001, c, 5'b00000, imm};
  endfunction

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0: return z;
      4'd1: return !z;
      4'd2: return cy;
      4'd3: return !cy;
      4'd4: return n;
      4'd5: return !n;
      4'd6: return v;
      4'd7: return !v;
      4'd8: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 32'd0;
    m_flags  = 4'd0;
    m_squash = 0;
  endtask

  task automatic drive_idle();
    bus.instr_in = NOP; bus.br_addr = 3'd0;
    bus.wb_en = 1'b0; bus.wb_addr = 3'd0; bus.wb_data = 32'd0;
    bus.flags_we = 1'b0; bus.flags_in = 4'd0;
  endtask

  // One clock of stimulus with full comparison against the model.
  task automatic cycle(input logic [31:0] ins, input logic we, input logic [2:0] wa,
                       input logic [31:0] wd, input logic fwe, input logic [3:0] fin,
                       input logic [2:0] ba);
    logic [6:0]  op;
    logic [2:0]  rs1, rs2;
    logic [3:0]  fl;
    logic        sq, taken, valid;
    logic [31:0] ea, eb;
    @(negedge clk);
    bus.instr_in = ins; bus.wb_en = we; bus.wb_addr = wa; bus.wb_data = wd;
    bus.flags_we = fwe; bus.flags_in = fin; bus.br_addr = ba;
    #1;
    check("br_value", bus.br_value, m_rf[ba]);
    check("write_enable", 32'(bus.write_enable), 32'(we));
    check("write_addr", 32'(bus.write_addr), 32'(wa));
    check("write_value", bus.write_value, wd);

    op  = ins[31:25];
    rs1 = ins[21:19];
    rs2 = ins[18:16];
    sq  = (m_squash > 0);
    fl  = (FWD && fwe) ? fin : m_flags;
    taken = !sq && op == 7'b1100001 && cond_ok(ins[24:21], fl);
    valid = !sq && ins != NOP && op != 7'b1100000 && op != 7'b1100001 && op != 7'b1100010;
    ea = (we && wa == rs1) ? wd : m_rf[rs1];
    if (op[0])                  eb = {{16{ins[15]}}, ins[15:0]};
    else if (we && wa == rs2)   eb = wd;
    else                        eb = m_rf[rs2];

    @(posedge clk);
    #1;
    check("b_cond", 32'(bus.b_cond), 32'(taken));
    check("b_relAddr", 32'(bus.b_relAddr), taken ? 32'(ins[15:0]) : 32'd0);
    check("ex_valid", 32'(bus.ex_valid), 32'(valid));
    if (valid) begin
      check("ex_opcode", 32'(bus.ex_opcode), 32'(op));
      check("ex_rd", 32'(bus.ex_rd), 32'(ins[24:22]));
      check("ex_op_a", bus.ex_op_a, ea);
      check("ex_op_b", bus.ex_op_b, eb);
    end

    if (we)  m_rf[wa] = wd;
    if (fwe) m_flags = fin;
    if (sq)         m_squash--;
    else if (taken) m_squash = SLOTS;
  endtask

  task automatic icyc(input logic [31:0] ins);
    cycle(ins, 1'b0, 3'd0, 32'd0, 1'b0, 4'd0, 3'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    int k;
    logic [6:0] op;
    k = $urandom_range(0, 9);
    case (k)
      0: return NOP;
      1: return {7'b1100000, 25'($urandom)};
      2: return {7'b1100010, 25'($urandom)};
      3, 4: return mkbc(4'($urandom_range(0, 15)), 16'($urandom));
      default: begin
        op = 7'($urandom_range(0, 63));
        return {op, 25'($urandom)};
      end
    endcase
  endfunction

  initial begin
    drive_idle();
    model_reset();
    #12;
    check("rst_b_cond", 32'(bus.b_cond), 32'd0);
    check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    check("rst_ex_opcode", 32'(bus.ex_opcode), 32'h64);
    check("rst_ex_op_a", bus.ex_op_a, 32'd0);
    check("rst_b_relAddr", 32'(bus.b_relAddr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write-back with same-cycle bypass and BR read-back.
    cycle(mk(ADD, 3'd1, 3'd3, 3'd0, 16'd0), 1'b1, 3'd3, 32'h1234, 1'b0, 4'd0, 3'd3);
    check("t2_op_a", bus.ex_op_a, 32'h1234);
    cycle(NOP, 1'b0, 3'd0, 32'd0, 1'b0, 4'd0, 3'd3);
    check("t2_br_value", bus.br_value, 32'h1234);

    // Sign-extended immediate.
    icyc(mk(ADDI, 3'd2, 3'd0, 3'd0, 16'hFFFE));
    check("t3_op_b", bus.ex_op_b, 32'hFFFFFFFE);

    // Taken EQ: one-cycle pulse, two squashed ADDs, third ADD valid.
    cycle(NOP, 1'b0, 3'd0, 32'd0, 1'b1, 4'b0100, 3'd0);
    icyc(mkbc(4'd0, 16'h0010));
    check("t4_b_cond", 32'(bus.b_cond), 32'd1);
    check("t4_rel", 32'(bus.b_relAddr), 32'h10);
    icyc(mk(ADD, 3'd1, 3'd3, 3'd3, 16'd0));
    check("t4_pulse_end", 32'(bus.b_cond), 32'd0);
    check("t4_sq1", 32'(bus.ex_valid), 32'd0);
    icyc(mk(ADD, 3'd1, 3'd3, 3'd3, 16'd0));
    check("t4_sq2", 32'(bus.ex_valid), 32'd0);
    icyc(mk(ADD, 3'd1, 3'd3, 3'd3, 16'd0));
    check("t4_resume", 32'(bus.ex_valid), 32'd1);

    // Not-taken NE with Z set.
    icyc(mkbc(4'd1, 16'h0020));
    check("t5_b_cond", 32'(bus.b_cond), 32'd0);
    icyc(mk(ADD, 3'd1, 3'd3, 3'd3, 16'd0));
    check("t5_valid", 32'(bus.ex_valid), 32'd1);

    // Same-cycle flag update versus Bcond.
    cycle(NOP, 1'b0, 3'd0, 32'd0, 1'b1, 4'b0000, 3'd0);
    cycle(mkbc(4'd0, 16'h0030), 1'b0, 3'd0, 32'd0, 1'b1, 4'b0100, 3'd0);
    check("t6_fwd", 32'(bus.b_cond), 32'(FWD));
    for (int i = 0; i < 3; i++) icyc(NOP);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cycle(rand_instr(), 1'($urandom), 3'($urandom), $urandom,
            ($urandom_range(0, 3) == 0), 4'($urandom), 3'($urandom));

    // Async reset mid-cycle during a squash window.
    cycle(NOP, 1'b1, 3'd5, 32'hA5A5_0001, 1'b0, 4'd0, 3'd0);
    icyc(mkbc(4'd8, 16'h0044));
    check("t1_pre_b_cond", 32'(bus.b_cond), 32'd1);
    @(negedge clk);
    drive_idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_b_cond", 32'(bus.b_cond), 32'd0);
    check("t1_ex_valid", 32'(bus.ex_valid), 32'd0);
    for (int a = 0; a < 8; a++) begin
      bus.br_addr = 3'(a);
      #1;
      check("t1_br_value", bus.br_value, 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    icyc(mk(ADD, 3'd4, 3'd5, 3'd5, 16'd0));
    check("t1_no_squash", 32'(bus.ex_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Instruction Decode stage paired with IF; it consumes the instruction stream that IF emits.
- Holds the 8x32 register file and the NZCV flags register.
- Decodes each instruction into operands for EX.
- Evaluates conditional branches and returns b_cond/b_relAddr to IF.
- Serves IF's BR register read (br_addr -> br_value) and broadcasts the write-back port so IF can bypass.
- Squashes wrong-path instructions after a taken conditional branch.

Parameters:
SQUASH_SLOTS, 2, number of instructions discarded after a taken conditional branch (1..3)
NOP_WORD, 32'hC8000000, encoding treated as NOP and emitted on squash

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
instr_in  in  32  instruction from IF (IF instruction_out)
br_addr  in  3  BR register index from IF
br_value  out  32  regfile[br_addr], combinational, no bypass (IF bypasses)
wb_en  in  1  EX/WB register write request
wb_addr  in  3  write-back register index
wb_data  in  32  write-back data
write_enable  out  1  = wb_en, combinational pass-through to IF
write_addr  out  3  = wb_addr
write_value  out  32  = wb_data
flags_we  in  1  EX flag update strobe
flags_in  in  4  {N,Z,C,V} from EX
b_cond  out  1  registered one-cycle pulse: conditional branch taken
b_relAddr  out  16  registered word offset (instr imm16)
ex_valid  out  1  decoded instruction valid to EX
ex_opcode  out  7  instr[31:25]
ex_rd  out  3  destination register
ex_op_a  out  32  operand A
ex_op_b  out  32  operand B

Behaviour:
- Format: [31:25] opcode, [24:22] rd, [21:19] rs1, [18:16] rs2, [15:0] imm16.
- Reset (async, rst_n=0): all 8 registers=0, flags=0, b_cond=0, b_relAddr=0, ex_valid=0, ex_opcode=NOP_WORD[31:25], ex_rd/ex_op_a/ex_op_b=0, squash counter=0, state=RUN. Reset mid-squash aborts the squash.
- Register write: at posedge when wb_en, regfile[wb_addr]<=wb_data. All 8 registers are writable.
- Flags: at posedge when flags_we, flags<=flags_in.
- Decode latency: 1 cycle; instr_in sampled at posedge, ex_* valid after that edge.
- Operands:
  - ex_op_a = R[rs1].
  - ex_op_b = opcode[0] ? sign-extended imm16 : R[rs2].
  - Any read where wb_en && wb_addr==rs uses wb_data (same-cycle bypass).
- B (1100000), BR (1100010), NOP (instr==NOP_WORD): ex_valid=0; IF resolves B/BR itself.
- Bcond (1100001), cond=instr[24:21]:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 AL 1; 9-15 never.
  - ex_valid=0.
  - If taken: b_cond<=1 and b_relAddr<=imm16 for exactly one cycle, then 0. Transition RUN->SQUASH, counter<=SQUASH_SLOTS.
- FSM:
  - RUN: normal decode.
  - SQUASH: each cycle decrement the counter; instr_in is treated as NOP, so ex_valid=0, no branch evaluation, b_cond=0. Return to RUN when the counter reaches 0.
  - Register writes and flag updates continue during SQUASH.
- Other opcodes: ex_valid=1.
- Simultaneous wb_en and decode of the same register: the bypass value wins. A write to the same register twice is not possible (single port).

Optional Feature:
ID_FLAG_FWD_EN
- Defined: Bcond evaluation uses flags_in when flags_we is high in the same cycle, else the flags register.
- Undefined: Bcond always uses the flags register, which is one cycle stale after an update.

Test Plan:
1. Reset with rst_n low mid-cycle -> b_cond=0, ex_valid=0, br_value=0 for br_addr 0..7 immediately (async).
2. wb_en=1, wb_addr=3, wb_data=32'h1234; same cycle decode ADD rs1=3 -> ex_op_a=32'h1234; next cycle with br_addr=3 -> br_value=32'h1234; write_value mirrors 32'h1234 combinationally.
3. Immediate op, opcode[0]=1, imm16=16'hFFFE -> ex_op_b=32'hFFFFFFFE.
4. flags=Z set, Bcond EQ, imm16=16'h0010 -> b_cond=1, b_relAddr=16'h0010 for one cycle. The next 2 instructions (ADDs) give ex_valid=0. The 3rd gives ex_valid=1.
5. Bcond NE with Z=1 -> b_cond stays 0, no squash, next instruction ex_valid=1.
6. flags_we=1, flags_in Z=1, with flags reg Z=0, same cycle Bcond EQ -> b_cond=1 with ID_FLAG_FWD_EN defined, 0 without.
